// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB interconnect:
//   - apb_state_e : transfer sequencer states
//   - SoC default address map (SRAM, system SRAM, UART windows)
//   - ERR_RDATA   : read data returned on any error termination
//   - idx_width() : width of a slave index for a given slave count
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } apb_state_e;

  localparam int unsigned MAP_NSLV = 3;

  localparam logic [31:0] SRAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] SRAM_MASK   = 32'h8000_0000;
  localparam logic [31:0] SYSRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] SYSRAM_MASK = 32'hF000_0000;
  localparam logic [31:0] UART_BASE   = 32'h9000_0000;
  localparam logic [31:0] UART_MASK   = 32'hF000_0000;

  localparam logic [MAP_NSLV*32-1:0] MAP_BASE = {UART_BASE, SYSRAM_BASE, SRAM_BASE};
  localparam logic [MAP_NSLV*32-1:0] MAP_MASK = {UART_MASK, SYSRAM_MASK, SRAM_MASK};

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_dec.sv
// -----------------------------------------------------------------------------
// apb_addr_dec
// Combinational priority address decoder. Slave i hits when
// (paddr & mask_i) == base_i; with overlapping windows the lowest index wins.
// Ports:
//   paddr    in  ADDR_WIDTH       address to decode
//   slv_base in  NSLV*ADDR_WIDTH  packed base addresses
//   slv_mask in  NSLV*ADDR_WIDTH  packed masks
//   hit      out 1                some window matched
//   idx      out IDX_W            index of the winning window (0 when no hit)
// -----------------------------------------------------------------------------
module apb_addr_dec
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NSLV       = 3,
  parameter int IDX_W      = idx_width(NSLV)
) (
  input  logic [ADDR_WIDTH-1:0]      paddr,
  input  logic [NSLV*ADDR_WIDTH-1:0] slv_base,
  input  logic [NSLV*ADDR_WIDTH-1:0] slv_mask,
  output logic                       hit,
  output logic [IDX_W-1:0]           idx
);

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((paddr & slv_mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          slv_base[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_xbar.sv
// -----------------------------------------------------------------------------
// apb_xbar
// Single-master APB interconnect. A master SETUP seen in IDLE is captured,
// decoded against NSLV base/mask windows and replayed to one slave as a
// registered SETUP/ACCESS pair; the slave response is returned for exactly
// one cycle. Unmapped addresses complete immediately with an error.
//
// Optional build macro:
//   APB_TIMEOUT_EN  an ACCESS phase lasting TIMEOUT_CYC cycles without
//                   s_pready is terminated with an error response.
//
// Ports:
//   clk, rts                 clock, synchronous active-high reset
//   m_paddr/m_pdata          master address / write data
//   m_psel/m_penable/m_pwrite/m_pstb  master controls and byte strobes
//   m_prdata/m_pready/m_perr master read data / completion / error
//   s_paddr/s_pdata/s_pwrite/s_pstb   registered, broadcast to all slaves
//   s_psel/s_penable         per-slave select / enable
//   s_prdata/s_pready/s_perr packed per-slave response
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a master SETUP; captures request and decode
// SETUP  | selected slave sees psel=1, penable=0
// ACCESS | selected slave sees psel=1, penable=1 until pready
// DONE   | slave response presented to master for one cycle
// ERR    | unmapped address: error presented to master for one cycle
// -----------------------------------------------------------------------------
module apb_xbar
  import apb_pkg::*;
#(
  parameter int                           ADDR_WIDTH  = 32,
  parameter int                           DATA_WIDTH  = 32,
  parameter int                           NSLV        = 3,
  parameter logic [NSLV*ADDR_WIDTH-1:0]   SLV_BASE    = {NSLV*ADDR_WIDTH{1'b0}},
  parameter logic [NSLV*ADDR_WIDTH-1:0]   SLV_MASK    = {NSLV*ADDR_WIDTH{1'b0}},
  parameter int                           TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rts,
  input  logic [ADDR_WIDTH-1:0]      m_paddr,
  input  logic [DATA_WIDTH-1:0]      m_pdata,
  input  logic                       m_psel,
  input  logic                       m_penable,
  input  logic                       m_pwrite,
  input  logic [3:0]                 m_pstb,
  output logic [DATA_WIDTH-1:0]      m_prdata,
  output logic                       m_pready,
  output logic                       m_perr,
  output logic [ADDR_WIDTH-1:0]      s_paddr,
  output logic [DATA_WIDTH-1:0]      s_pdata,
  output logic                       s_pwrite,
  output logic [3:0]                 s_pstb,
  output logic [NSLV-1:0]            s_psel,
  output logic [NSLV-1:0]            s_penable,
  input  logic [NSLV*DATA_WIDTH-1:0] s_prdata,
  input  logic [NSLV-1:0]            s_pready,
  input  logic [NSLV-1:0]            s_perr
);

  localparam int IDX_W = idx_width(NSLV);

  apb_state_e             state, state_n;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   perr_q;

  logic                   dec_hit;
  logic [IDX_W-1:0]       dec_idx;
  logic                   start;
  logic                   slv_ready;
  logic                   slv_err;
  logic [DATA_WIDTH-1:0]  slv_rdata;
  logic                   timeout_hit;

  apb_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NSLV       (NSLV),
    .IDX_W      (IDX_W)
  ) u_dec (
    .paddr    (m_paddr),
    .slv_base (SLV_BASE),
    .slv_mask (SLV_MASK),
    .hit      (dec_hit),
    .idx      (dec_idx)
  );

  assign start = m_psel && !m_penable;

  // Response mux for the latched slave index.
  always_comb begin
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slv_ready = s_pready[i];
        slv_err   = s_perr[i];
        slv_rdata = s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] to_cnt;

  // Counts ACCESS cycles; restarted from SETUP so each transfer gets a
  // full window.
  always_ff @(posedge clk) begin
    if (rts) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ACCESS) && (to_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rts) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = dec_hit ? SETUP : ERR;
        end
      end
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        // A response in the terminal timeout cycle takes priority.
        if (slv_ready || timeout_hit) begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rts) begin
      s_paddr  <= '0;
      s_pdata  <= '0;
      s_pwrite <= 1'b0;
      s_pstb   <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      perr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_paddr  <= m_paddr;
            s_pdata  <= m_pdata;
            s_pwrite <= m_pwrite;
            s_pstb   <= m_pstb;
            idx_q    <= dec_idx;
            rdata_q  <= '0;
            perr_q   <= 1'b0;
          end
        end
        ACCESS: begin
          if (slv_ready) begin
            rdata_q <= slv_rdata;
            perr_q  <= slv_err;
          end else if (timeout_hit) begin
            rdata_q <= DATA_WIDTH'(ERR_RDATA);
            perr_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    s_psel    = '0;
    s_penable = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        s_psel[i]    = (state == SETUP) || (state == ACCESS);
        s_penable[i] = (state == ACCESS);
      end
    end
  end

  assign m_pready = (state == DONE) || (state == ERR);
  assign m_perr   = (state == ERR) || ((state == DONE) && perr_q);
  assign m_prdata = (state == DONE) ? rdata_q : DATA_WIDTH'(ERR_RDATA);

endmodule
